// File: rtl/hansen_mmio_pkg.sv
// Memory map constants for the hansen_core data port: MMIO page base, register
// offsets and CON_STATUS bit layout, shared with core benches and firmware.
package hansen_mmio_pkg;

    localparam logic [31:0] MMIO_BASE_DEFAULT = 32'h8000_0000;

    localparam logic [7:0] OFF_CON_TX      = 8'h00;
    localparam logic [7:0] OFF_CON_STATUS  = 8'h04;
    localparam logic [7:0] OFF_MTIME_LO    = 8'h08;
    localparam logic [7:0] OFF_MTIME_HI    = 8'h0C;
    localparam logic [7:0] OFF_MTIMECMP_LO = 8'h10;
    localparam logic [7:0] OFF_MTIMECMP_HI = 8'h14;
    localparam logic [7:0] OFF_HALT        = 8'h18;

    localparam int STAT_FULL      = 0;
    localparam int STAT_EMPTY     = 1;
    localparam int STAT_OVERFLOW  = 2;
    localparam int STAT_COUNT_LSB = 8;

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_RAM  = 2'd1,
        SEL_MMIO = 2'd2
    } sel_e;

endpackage

// File: rtl/hansen_sync_fifo.sv
// Single-clock FIFO with occupancy count; a push into a full FIFO is accepted
// when a pop happens in the same cycle.
module hansen_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign rdata   = mem[rd_ptr];

    // When full, wr_ptr == rd_ptr; the head is read combinationally before the
    // edge overwrites it, so push-with-pop on a full FIFO is safe.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/hansen_dmem_responder.sv
// Data-memory target for hansen_core: word RAM plus an MMIO page with console
// TX FIFO, 64-bit mtime/mtimecmp timer and a sticky halt register.
module hansen_dmem_responder
    import hansen_mmio_pkg::*;
#(
    parameter int          RAM_WORDS = 1024,
    parameter int          CON_DEPTH = 4,
    parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata,
    input  logic        dmem_we,
    output logic [31:0] dmem_rdata,
    output logic [7:0]  con_data,
    output logic        con_valid,
    input  logic        con_ready,
    output logic        timer_irq,
    output logic        halt,
    output logic [31:0] halt_code
);

    localparam int AW = $clog2(RAM_WORDS);
    localparam int CW = $clog2(CON_DEPTH) + 1;

    sel_e        sel;
    logic [7:0]  off;
    logic        wr_mmio;
    logic        wr_con_tx;
    logic        wr_con_status;
    logic        wr_mtime_lo;
    logic        wr_mtime_hi;
    logic        wr_mtimecmp_lo;
    logic        wr_mtimecmp_hi;
    logic        wr_halt;

    logic [31:0] ram [RAM_WORDS];
    logic [31:0] ram_rdata;

    logic [63:0] mtime;
    logic [63:0] mtime_next;
    logic [63:0] mtimecmp;
    logic [63:0] mtimecmp_next;

    logic [7:0]    fifo_rdata;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic          fifo_pop;
    logic          overflow;
    logic [31:0]   con_status;

    // RAM decode wins so a low MMIO_BASE can never shadow RAM.
    always_comb begin
        sel = SEL_NONE;
        if (dmem_addr < 32'(4 * RAM_WORDS)) begin
            sel = SEL_RAM;
        end else if (dmem_addr[31:8] == MMIO_BASE[31:8]) begin
            sel = SEL_MMIO;
        end
    end

    assign off            = {dmem_addr[7:2], 2'b00};
    assign wr_mmio        = dmem_we && (sel == SEL_MMIO);
    assign wr_con_tx      = wr_mmio && (off == OFF_CON_TX);
    assign wr_con_status  = wr_mmio && (off == OFF_CON_STATUS);
    assign wr_mtime_lo    = wr_mmio && (off == OFF_MTIME_LO);
    assign wr_mtime_hi    = wr_mmio && (off == OFF_MTIME_HI);
    assign wr_mtimecmp_lo = wr_mmio && (off == OFF_MTIMECMP_LO);
    assign wr_mtimecmp_hi = wr_mmio && (off == OFF_MTIMECMP_HI);
    assign wr_halt        = wr_mmio && (off == OFF_HALT);

    always_ff @(posedge clk) begin
        if (dmem_we && (sel == SEL_RAM)) begin
            ram[dmem_addr[AW+1:2]] <= dmem_wdata;
        end
    end

    assign ram_rdata = ram[dmem_addr[AW+1:2]];

    always_comb begin
        mtime_next = mtime + 64'd1;
        if (wr_mtime_lo) begin
            mtime_next = {mtime[63:32], dmem_wdata};
        end else if (wr_mtime_hi) begin
            mtime_next = {dmem_wdata, mtime[31:0]};
        end
        mtimecmp_next = mtimecmp;
        if (wr_mtimecmp_lo) begin
            mtimecmp_next = {mtimecmp[63:32], dmem_wdata};
        end else if (wr_mtimecmp_hi) begin
            mtimecmp_next = {dmem_wdata, mtimecmp[31:0]};
        end
    end

    // timer_irq samples the already-updated registers, giving one cycle of lag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mtime     <= '0;
            mtimecmp  <= '1;
            timer_irq <= 1'b0;
        end else begin
            mtime     <= mtime_next;
            mtimecmp  <= mtimecmp_next;
            timer_irq <= (mtime >= mtimecmp);
        end
    end

    // con_valid/con_ready: a byte transfers on every posedge where both are high;
    // con_data holds steady while con_valid is high and con_ready is low.
    assign fifo_pop  = con_valid && con_ready;
    assign con_valid = !fifo_empty;
    assign con_data  = fifo_empty ? 8'h00 : fifo_rdata;

    hansen_sync_fifo #(
        .WIDTH (8),
        .DEPTH (CON_DEPTH)
    ) u_con_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wr_con_tx),
        .wdata (dmem_wdata[7:0]),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (wr_con_status) begin
            overflow <= 1'b0;
        end else if (wr_con_tx && fifo_full && !fifo_pop) begin
            overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            halt      <= 1'b0;
            halt_code <= '0;
        end else if (wr_halt && !halt) begin
            halt      <= 1'b1;
            halt_code <= dmem_wdata;
        end
    end

    always_comb begin
        con_status                       = '0;
        con_status[STAT_COUNT_LSB +: 8]  = 8'(fifo_count);
        con_status[STAT_OVERFLOW]        = overflow;
        con_status[STAT_EMPTY]           = fifo_empty;
        con_status[STAT_FULL]            = fifo_full;
    end

    always_comb begin
        dmem_rdata = '0;
        case (sel)
            SEL_RAM: dmem_rdata = ram_rdata;
            SEL_MMIO: begin
                case (off)
                    OFF_CON_STATUS:  dmem_rdata = con_status;
                    OFF_MTIME_LO:    dmem_rdata = mtime[31:0];
                    OFF_MTIME_HI:    dmem_rdata = mtime[63:32];
                    OFF_MTIMECMP_LO: dmem_rdata = mtimecmp[31:0];
                    OFF_MTIMECMP_HI: dmem_rdata = mtimecmp[63:32];
                    OFF_HALT:        dmem_rdata = halt_code;
                    default:         dmem_rdata = '0;
                endcase
            end
            default: dmem_rdata = '0;
        endcase
    end

endmodule

// File: doc/hansen_dmem_responder.md
Name: hansen_dmem_responder

Overview:
Target side of the hansen_core data-memory port. Connects to dmem_addr, dmem_wdata, dmem_we and dmem_rdata, and answers core loads and stores from a word RAM plus a small MMIO page. The MMIO page holds a console TX FIFO, a 64-bit mtime/mtimecmp timer and a sticky halt register. It serves as the standard data memory for simulation benches and FPGA bring-up.

Parameters:
RAM_WORDS, 1024, RAM depth in 32-bit words (power of 2); RAM occupies 0x0000_0000 .. 4*RAM_WORDS-1
CON_DEPTH, 4, console FIFO depth in bytes (power of 2, >=2)
MMIO_BASE, 32'h8000_0000, base of the MMIO page (decode on addr[31:8])

Ports:
clk  in  1  core clock
reset  in  1  asynchronous, active-high reset
dmem_addr  in  32  byte address from core, word aligned; addr[1:0] ignored
dmem_wdata  in  32  store data
dmem_we  in  1  store strobe, sampled at posedge clk
dmem_rdata  out  32  load data, combinational from dmem_addr
con_data  out  8  console byte at FIFO head
con_valid  out  1  FIFO non-empty
con_ready  in  1  console sink accepts con_data this cycle
timer_irq  out  1  registered (mtime >= mtimecmp)
halt  out  1  sticky halt flag
halt_code  out  32  value written to HALT

Behaviour:
- Reset values: con_valid=0, con_data=0, timer_irq=0, halt=0, halt_code=0, mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, FIFO empty, overflow=0. RAM contents are not reset.
- Reads have zero latency. dmem_rdata is a pure function of dmem_addr and current state; there is no read strobe, so reads have no side effects.
- Writes take effect at the posedge where dmem_we=1; a read of the same location returns the new value from the next cycle on.
- Decode:
  - RAM when addr < 4*RAM_WORDS; index = addr[log2(RAM_WORDS)+1:2].
  - MMIO when addr[31:8]==MMIO_BASE[31:8].
  - Anything else is unmapped: reads return 0, writes are ignored.
- MMIO offsets (byte):
  - 0x00 CON_TX: write pushes wdata[7:0]; read returns 0.
  - 0x04 CON_STATUS: read {16'b0, count[7:0], 5'b0, overflow, empty, full}; any write clears overflow.
  - 0x08 MTIME_LO, 0x0C MTIME_HI: read/write.
  - 0x10 MTIMECMP_LO, 0x14 MTIMECMP_HI: read/write.
  - 0x18 HALT: write sets halt; read returns halt_code.
  - Undefined offsets read 0, writes ignored.
- Console FIFO:
  - con_valid = !empty; con_data = head byte, forced to 0 when empty.
  - Pop on con_valid && con_ready.
  - Push is accepted if !full, or if a pop occurs in the same cycle.
  - A push into a full FIFO with no concurrent pop is dropped and sets overflow (sticky).
  - count is in 0..CON_DEPTH; pointers wrap modulo CON_DEPTH.
- Timer:
  - mtime increments by 1 every cycle, wrapping 2^64 -> 0.
  - A write to MTIME_LO/HI replaces that half with wdata, and mtime does not increment that cycle.
  - timer_irq is registered and reflects the comparison of the post-update mtime/mtimecmp values (1-cycle lag).
  - Reads of LO and HI are not atomic; software uses a HI/LO/HI read sequence.
- Halt:
  - The first HALT write sets halt=1 and halt_code=wdata at the posedge.
  - Later HALT writes are ignored until reset.
  - Halt does not freeze the timer, RAM or FIFO.
- Reset asserted mid-operation: all registers return to reset values immediately, without waiting for clk, and the FIFO contents are discarded.

Decomposition:
- Package hansen_mmio_pkg holds MMIO_BASE default, the offset constants (OFF_CON_TX, OFF_CON_STATUS, OFF_MTIME_LO/HI, OFF_MTIMECMP_LO/HI, OFF_HALT) and the CON_STATUS bit positions. The same constants are shared with core benches and firmware headers.
- One sub-module, hansen_sync_fifo (parameters WIDTH, DEPTH): push/pop, full/empty/count, same-cycle push-when-full-with-pop accepted. It is instantiated for the console.

Test Plan:
1. RAM: store 0xCAFEF00D to 0x100, then load 0x100 -> 0xCAFEF00D from the next cycle. Load 0x4000_0000 -> 0. Store to 0x4000_0000 -> RAM and MMIO state unchanged.
2. Console:
   - Stimulus: con_ready=0, store 0x48 then 0x69 to 0x8000_0000.
   - Check: CON_STATUS -> count=2, empty=0; con_valid=1, con_data=0x48.
   - Then raise con_ready: 0x48 and 0x69 pop on consecutive cycles, then con_valid=0 and con_data=0.
3. Overflow:
   - Stimulus: con_ready=0, push 5 bytes 0x01..0x05.
   - Check: count=4, full=1, overflow=1; drain order is 0x01..0x04.
   - Store any value to CON_STATUS -> overflow=0.
   - With the FIFO full and con_ready=1 in the same cycle as a push: push accepted, count stays 4, overflow stays 0.
4. Timer:
   - Stimulus: store MTIMECMP_HI=0, MTIMECMP_LO=20, then MTIME_LO=0.
   - Check: timer_irq=0 until mtime reads 20, asserted exactly 1 cycle after mtime reaches 20.
   - Store MTIMECMP_LO=0xFFFF_FFFF -> timer_irq drops 1 cycle later.
5. Halt:
   - Store 0x1 to 0x8000_0018 -> halt=1, halt_code=1 after that edge.
   - Store 0x7 -> halt_code stays 1, and a load from 0x8000_0018 returns 1.
6. Async reset: pulse reset between clock edges with FIFO count=3, mtime nonzero and halt=1 -> con_valid, halt, halt_code, timer_irq and mtime are 0 before the next posedge, CON_STATUS reads empty=1.
